cart_usb_arbiter: RTL and testbench

CART_USB_ARBITER -- requirements
Module: cart_usb_arbiter

---
 rtl/cart_usb_arbiter_pkg.sv | 36 +++
 rtl/cart_usb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_cart_usb_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_usb_arbiter_pkg.sv
// Shared definitions for the cartridge/USB SDRAM arbiter.
//   - default bus widths and starvation limit
//   - USB transfer-type codes
//   - arbiter FSM state encoding
//   - helper for sizing the starvation counter
package cart_usb_arbiter_pkg;

  localparam int ADDR_W_DEF       = 26;
  localparam int DATA_W_DEF       = 16;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [2:0] {
    USB_NONE = 3'b000,
    USB_CODE = 3'b001,
    USB_V    = 3'b010,
    USB_KS   = 3'b011,
    USB_SR   = 3'b101,
    USB_SL   = 3'b110
  } usb_type_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE_CART = 3'd1,
    ST_ISSUE_USB  = 3'd2,
    ST_WAIT       = 3'd3,
    ST_DONE       = 3'd4
  } arb_state_e;

  // Bits needed to count 0..limit inclusive; never less than one bit.
  function automatic int starve_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cart_usb_arbiter.sv
// Arbitrates the single SDRAM port between the cartridge bus and the USB
// host. Each granted transaction strobes the buffer stage once (which
// translates the address and advances its offset), then issues one memory
// request and returns a one-cycle ack to the granted side.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   cart_req/we/addr_in/wdata   cartridge request (held until cart_ack)
//   cart_ack, cart_rdata        cartridge completion pulse, read data
//   usb_req/we/type/wdata       USB request (held until usb_ack)
//   usb_ack, usb_rdata          USB completion pulse, read data
//   from_cart, from_usb         buffer-stage strobes (one cycle per grant)
//   cart_addr, usb_trans_type   buffer-stage selectors
//   buf_mem_addr                translated address from the buffer stage
//   mem_req/we/addr/wdata       SDRAM request, held until mem_ack
//   mem_ack, mem_rdata          SDRAM completion and read data
//
// state         | meaning
// --------------+-----------------------------------------------------
// ST_IDLE       | arbitrate between cart_req and usb_req
// ST_ISSUE_CART | strobe buffer stage for cart, capture address/data
// ST_ISSUE_USB  | strobe buffer stage for USB, capture address/data
// ST_WAIT       | mem_req held until mem_ack (skipped for USB NONE)
// ST_DONE       | ack pulse to the granted side
module cart_usb_arbiter
  import cart_usb_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cart_req,
  input  logic              cart_we,
  input  logic [ADDR_W-1:0] cart_addr_in,
  input  logic [DATA_W-1:0] cart_wdata,
  output logic              cart_ack,
  output logic [DATA_W-1:0] cart_rdata,

  input  logic              usb_req,
  input  logic              usb_we,
  input  logic [2:0]        usb_type,
  input  logic [DATA_W-1:0] usb_wdata,
  output logic              usb_ack,
  output logic [DATA_W-1:0] usb_rdata,

  output logic              from_cart,
  output logic              from_usb,
  output logic [ADDR_W-1:0] cart_addr,
  output logic [2:0]        usb_trans_type,
  input  logic [ADDR_W-1:0] buf_mem_addr,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STARVE_W = starve_width(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state;
  logic [STARVE_W-1:0] starve_cnt;
  logic                grant_usb;  // side owning the in-flight transaction
  logic                no_access;  // USB NONE: complete without touching memory

  // USB wins only when it has been starved long enough, or cart is idle.
  logic usb_wins;
  assign usb_wins = usb_req && (!cart_req || (starve_cnt == STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      starve_cnt     <= '0;
      grant_usb      <= 1'b0;
      no_access      <= 1'b0;
      from_cart      <= 1'b0;
      from_usb       <= 1'b0;
      cart_addr      <= '0;
      usb_trans_type <= 3'b000;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      cart_ack       <= 1'b0;
      usb_ack        <= 1'b0;
      cart_rdata     <= '0;
      usb_rdata      <= '0;
    end else begin
      // single-cycle pulses
      from_cart <= 1'b0;
      from_usb  <= 1'b0;
      cart_ack  <= 1'b0;
      usb_ack   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (usb_wins) begin
            state          <= ST_ISSUE_USB;
            from_usb       <= 1'b1;
            usb_trans_type <= usb_type;
            grant_usb      <= 1'b1;
            starve_cnt     <= '0;
          end else if (cart_req) begin
            state     <= ST_ISSUE_CART;
            from_cart <= 1'b1;
            cart_addr <= cart_addr_in;
            grant_usb <= 1'b0;
            if (!usb_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else begin
            // nothing pending; usb_req is necessarily low here
            starve_cnt <= '0;
          end
        end

        ST_ISSUE_CART: begin
          mem_addr  <= buf_mem_addr;
          mem_we    <= cart_we;
          mem_wdata <= cart_wdata;
          mem_req   <= 1'b1;
          no_access <= 1'b0;
          state     <= ST_WAIT;
        end

        ST_ISSUE_USB: begin
          mem_addr  <= buf_mem_addr;
          mem_wdata <= usb_wdata;
          if (usb_trans_type == USB_NONE) begin
            mem_we    <= 1'b0;
            mem_req   <= 1'b0;
            no_access <= 1'b1;
          end else begin
            mem_we    <= usb_we;
            mem_req   <= 1'b1;
            no_access <= 1'b0;
          end
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (no_access) begin
            // NONE transfers still pass through WAIT so every grant has
            // the same minimum cadence; mem_ack is not consulted.
            usb_ack <= 1'b1;
            state   <= ST_DONE;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ST_DONE;
            if (grant_usb) begin
              usb_ack <= 1'b1;
              if (!mem_we) usb_rdata <= mem_rdata;
            end else begin
              cart_ack <= 1'b1;
              if (!mem_we) cart_rdata <= mem_rdata;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cart_usb_arbiter.sv
module tb_cart_usb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cart_req, cart_we;
  logic [25:0] cart_addr_in;
  logic [15:0] cart_wdata;
  logic        cart_ack;
  logic [15:0] cart_rdata;
  logic        usb_req, usb_we;
  logic [2:0]  usb_type;
  logic [15:0] usb_wdata;
  logic        usb_ack;
  logic [15:0] usb_rdata;
  logic        from_cart, from_usb;
  logic [25:0] cart_addr;
  logic [2:0]  usb_trans_type;
  logic [25:0] buf_mem_addr;
  logic        mem_req, mem_we;
  logic [25:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  cart_usb_arbiter dut (
    .clk(clk), .rst(rst),
    .cart_req(cart_req), .cart_we(cart_we), .cart_addr_in(cart_addr_in),
    .cart_wdata(cart_wdata), .cart_ack(cart_ack), .cart_rdata(cart_rdata),
    .usb_req(usb_req), .usb_we(usb_we), .usb_type(usb_type),
    .usb_wdata(usb_wdata), .usb_ack(usb_ack), .usb_rdata(usb_rdata),
    .from_cart(from_cart), .from_usb(from_usb), .cart_addr(cart_addr),
    .usb_trans_type(usb_trans_type), .buf_mem_addr(buf_mem_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // buffer stage model: cart addresses offset by 0x10, USB mapped by type
  assign buf_mem_addr = from_cart ? (cart_addr + 26'h10)
                                  : (26'h3000000 | {23'b0, usb_trans_type});

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor: cycle k is labelled #1 after posedge k
  int cyc = 0;
  int n_fc = 0, n_fu = 0, n_mr = 0, n_ca = 0, n_ua = 0;
  int t_strobe = 0, t_memreq = 0, t_cack = 0, t_uack = 0;
  int excl_viol = 0, strobe_viol = 0, outstanding = 0;
  int last_strobe = -1, min_gap = 1000;
  logic        mem_req_q = 1'b0;
  logic [25:0] seen_addr = '0;
  logic        seen_we = 1'b0;
  logic [15:0] seen_wdata = '0;
  string glog = "";

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (from_cart && from_usb) excl_viol++;
    if (rst) begin
      outstanding = 0;
    end else begin
      if (from_cart || from_usb) begin
        if (outstanding != 0) strobe_viol++;
        outstanding = 1;
        if (last_strobe >= 0 && (cyc - last_strobe) < min_gap) min_gap = cyc - last_strobe;
        last_strobe = cyc;
        t_strobe = cyc;
      end
      if (cart_ack || usb_ack) begin
        if (outstanding == 0) strobe_viol++;
        outstanding = 0;
      end
    end
    if (from_cart) begin n_fc++; glog = {glog, "C"}; end
    if (from_usb)  begin n_fu++; glog = {glog, "U"}; end
    if (mem_req && !mem_req_q) begin
      n_mr++;
      t_memreq   = cyc;
      seen_addr  = mem_addr;
      seen_we    = mem_we;
      seen_wdata = mem_wdata;
    end
    mem_req_q = mem_req;
    if (cart_ack) begin n_ca++; t_cack = cyc; end
    if (usb_ack)  begin n_ua++; t_uack = cyc; end
  end

  // SDRAM model: ack mem_lat cycles after the first mem_req cycle
  int          mem_lat = 3;
  logic [15:0] mem_data = '0;
  int          inj_req = 0, inj_done = 0;
  int          t_mack = 0;
  int          mcnt = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        mcnt = 0;
      end else if (inj_req != inj_done) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        inj_done  = inj_req;
      end else if (mem_req) begin
        mcnt++;
        if (mcnt == mem_lat + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_data;
          t_mack    = cyc;
          mcnt      = 0;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cart_txn(input logic [25:0] a, input logic we, input logic [15:0] wd,
                          output int t_req);
    bit ok;
    @(negedge clk);
    cart_addr_in = a; cart_we = we; cart_wdata = wd; cart_req = 1'b1;
    t_req = cyc;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cart_ack) begin ok = 1'b1; break; end
    end
    cart_req = 1'b0;
    chk("cart_ack_seen", 32'(ok), 1);
  endtask

  task automatic usb_txn(input logic [2:0] ty, input logic we, input logic [15:0] wd,
                         output int t_req);
    bit ok;
    @(negedge clk);
    usb_type = ty; usb_we = we; usb_wdata = wd; usb_req = 1'b1;
    t_req = cyc;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (usb_ack) begin ok = 1'b1; break; end
    end
    usb_req = 1'b0;
    chk("usb_ack_seen", 32'(ok), 1);
  endtask

  initial begin
    int tr, b_fc, b_fu, b_mr, b_ca, b_ua, glen, acks;
    bit ok;
    string got_s, exp_s;

    rst = 1'b1;
    cart_req = 1'b0; cart_we = 1'b0; cart_addr_in = '0; cart_wdata = '0;
    usb_req = 1'b0; usb_we = 1'b0; usb_type = 3'b000; usb_wdata = '0;
    idle(3);
    chk("rst_mem_req",  32'(mem_req), 0);
    chk("rst_mem_we",   32'(mem_we), 0);
    chk("rst_strobes",  32'({from_cart, from_usb}), 0);
    chk("rst_acks",     32'({cart_ack, usb_ack}), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_rdata",    32'({cart_rdata, usb_rdata}), 0);
    rst = 1'b0;
    idle(2);

    // cart read, mem_ack three cycles after mem_req
    mem_lat = 3; mem_data = 16'hBEEF;
    b_fc = n_fc; b_fu = n_fu; b_ca = n_ca; b_ua = n_ua;
    cart_txn(26'h0001234, 1'b0, 16'h0, tr);
    idle(3);
    chk("c1_strobe_cnt",  n_fc - b_fc, 1);
    chk("c1_usb_strobe",  n_fu - b_fu, 0);
    chk("c1_strobe_lat",  t_strobe - tr, 1);
    chk("c1_memreq_lat",  t_memreq - t_strobe, 1);
    chk("c1_mem_addr",    32'(seen_addr), 'h0001244);
    chk("c1_mem_we",      32'(seen_we), 0);
    chk("c1_mack_lat",    t_mack - t_memreq, 3);
    chk("c1_ack_lat",     t_cack - t_mack, 1);
    chk("c1_ack_cycles",  n_ca - b_ca, 1);
    chk("c1_usb_ack",     n_ua - b_ua, 0);
    chk("c1_rdata",       32'(cart_rdata), 'hBEEF);

    // USB read, type CODE
    mem_lat = 1; mem_data = 16'h1357;
    usb_txn(3'b001, 1'b0, 16'h0, tr);
    idle(2);
    chk("u1_mem_addr",   32'(seen_addr), 'h3000001);
    chk("u1_rdata",      32'(usb_rdata), 'h1357);
    chk("u1_cart_rdata", 32'(cart_rdata), 'hBEEF);

    // USB write, type CODE
    mem_lat = 2; mem_data = 16'h7777;
    usb_txn(3'b001, 1'b1, 16'h5A5A, tr);
    idle(2);
    chk("uw_mem_we",    32'(seen_we), 1);
    chk("uw_mem_wdata", 32'(seen_wdata), 'h5A5A);
    chk("uw_usb_rdata", 32'(usb_rdata), 'h1357);
    chk("uw_we_clear",  32'(mem_we), 0);

    // USB NONE: no memory access
    b_mr = n_mr; b_fu = n_fu;
    usb_txn(3'b000, 1'b0, 16'h0, tr);
    idle(2);
    chk("un_mem_req",  n_mr - b_mr, 0);
    chk("un_strobe",   n_fu - b_fu, 1);
    chk("un_ack_lat",  t_uack - tr, 3);
    chk("un_rdata",    32'(usb_rdata), 'h1357);

    // requester drops cart_req right after the grant
    mem_lat = 2; mem_data = 16'h4242;
    b_ca = n_ca;
    @(negedge clk);
    cart_addr_in = 26'h0000ABC; cart_we = 1'b0; cart_req = 1'b1;
    @(negedge clk);
    cart_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cart_ack) begin ok = 1'b1; break; end
    end
    chk("drop_ack_seen", 32'(ok), 1);
    idle(2);
    chk("drop_ack_cnt",  n_ca - b_ca, 1);
    chk("drop_rdata",    32'(cart_rdata), 'h4242);

    // stray mem_ack while idle
    b_ca = n_ca; b_ua = n_ua; b_mr = n_mr;
    inj_req = inj_req + 1;
    idle(5);
    chk("spur_acks",   (n_ca - b_ca) + (n_ua - b_ua), 0);
    chk("spur_rdata",  32'(cart_rdata), 'h4242);
    chk("spur_usb_rd", 32'(usb_rdata), 'h1357);

    // starvation: both held continuously
    mem_lat = 0; mem_data = 16'h0101;
    glen = glog.len();
    @(negedge clk);
    cart_addr_in = 26'h0000100; cart_we = 1'b0; cart_req = 1'b1;
    usb_type = 3'b010; usb_we = 1'b0; usb_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cart_ack || usb_ack) acks++;
      if (acks == 10) break;
    end
    cart_req = 1'b0; usb_req = 1'b0;
    idle(4);
    chk("st_acks", acks, 10);
    got_s = glog.substr(glen, glen + 9);
    exp_s = "CCCCUCCCCU";
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("st_grant%0d", i), 32'(got_s[i]), 32'(exp_s[i]));
    end

    // reset one cycle into WAIT
    mem_lat = 10;
    b_ca = n_ca;
    @(negedge clk);
    cart_addr_in = 26'h0000055; cart_we = 1'b0; cart_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin ok = 1'b1; break; end
    end
    chk("rw_mem_req_up", 32'(ok), 1);
    @(negedge clk);
    rst = 1'b1; cart_req = 1'b0;
    #1;
    chk("rw_mem_req_drop", 32'(mem_req), 0);
    chk("rw_rdata_clr",    32'(cart_rdata), 0);
    idle(2);
    rst = 1'b0;
    idle(15);
    chk("rw_no_ack", n_ca - b_ca, 0);
    mem_lat = 2; mem_data = 16'h0F0F;
    cart_txn(26'h0000022, 1'b0, 16'h0, tr);
    idle(2);
    chk("rw_next_addr",  32'(seen_addr), 'h0000032);
    chk("rw_next_rdata", 32'(cart_rdata), 'h0F0F);
    chk("rw_next_lat",   t_strobe - tr, 1);

    // whole-run properties
    chk("strobe_exclusive", excl_viol, 0);
    chk("strobe_per_ack",   strobe_viol, 0);
    chk("grant_min_gap",    min_gap, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
